// File: rtl/uart_echo_checker.sv
// UART loopback checker: sends NUM_BYTES bytes starting at SEED, expects byte+1 back.
// Optional macro UART_CHK_ABORT_ON_FAIL_EN ends the run on the first mismatch or timeout.
module uart_echo_checker #(
   parameter int unsigned NUM_BYTES      = 16,
   parameter logic [7:0]  SEED           = 8'h00,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] pass_count,
   output logic [7:0] fail_count,
   output logic [7:0] timeout_count,
   output logic [7:0] last_bad
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] I_LAST = 8'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state;
   logic [7:0]    index;
   logic [7:0]    expected;
   logic [TW-1:0] timer;

   logic hit;
   logic miss;
   logic tmo;
   logic stop;

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // rx_valid has priority over an expiring timer
   assign hit  = (state == S_WAIT) && rx_valid && (rx_data == expected);
   assign miss = (state == S_WAIT) && rx_valid && (rx_data != expected);
   assign tmo  = (state == S_WAIT) && !rx_valid && (timer == T_LAST);

`ifdef UART_CHK_ABORT_ON_FAIL_EN
   assign stop = (index == I_LAST) || miss || tmo;
`else
   assign stop = (index == I_LAST);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         index         <= 8'd0;
         expected      <= 8'd0;
         timer         <= '0;
         tx_data       <= 8'd0;
         tx_valid      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass_count    <= 8'd0;
         fail_count    <= 8'd0;
         timeout_count <= 8'd0;
         last_bad      <= 8'd0;
      end else begin
         tx_valid <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  pass_count    <= 8'd0;
                  fail_count    <= 8'd0;
                  timeout_count <= 8'd0;
                  index         <= 8'd0;
                  state         <= S_SEND;
                  busy          <= 1'b1;
                  done          <= 1'b0;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_data  <= SEED + index;
                  tx_valid <= 1'b1;
                  expected <= SEED + index + 8'd1;
                  timer    <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               timer <= timer + TW'(1);
               if (hit) begin
                  pass_count <= sat_inc(pass_count);
               end
               if (miss) begin
                  fail_count <= sat_inc(fail_count);
                  last_bad   <= rx_data;
               end
               if (tmo) begin
                  fail_count    <= sat_inc(fail_count);
                  timeout_count <= sat_inc(timeout_count);
               end
               if (hit || miss || tmo) begin
                  if (stop) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     index <= index + 8'd1;
                     state <= S_SEND;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: echo model, vector table of full runs, corner sequences.
// Expected values are hand-derived for SEED=F8, 16 bytes, 1000-cycle timeout.
module tb_uart_echo_checker;

   localparam int unsigned NB = 16;
   localparam logic [7:0] SEED = 8'hF8;
   localparam int unsigned TO = 1000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic [7:0] pass_count;
   logic [7:0] fail_count;
   logic [7:0] timeout_count;
   logic [7:0] last_bad;

   logic       m_rx_valid = 1'b0;
   logic [7:0] m_rx_data = 8'd0;
   logic       inj_valid;
   logic [7:0] inj_data;

   int passed = 0;
   int total = 0;

   always #5 clk = ~clk;

   assign rx_valid = m_rx_valid | inj_valid;
   assign rx_data  = inj_valid ? inj_data : m_rx_data;

   uart_echo_checker #(
      .NUM_BYTES(NB),
      .SEED(SEED),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .busy(busy),
      .done(done),
      .pass_count(pass_count),
      .fail_count(fail_count),
      .timeout_count(timeout_count),
      .last_bad(last_bad)
   );

   // echo model: byte+1 returned so the DUT sees it when its timer equals dly
   int unsigned cyc = 0;
   int unsigned sent_total = 0;
   int unsigned base = 0;
   int unsigned seq_err = 0;
   int unsigned tx_cyc [NB];
   logic [15:0] cur_bad = '0;
   logic [15:0] cur_drop = '0;
   logic [15:0] cur_late = '0;
   int unsigned cur_delay = 100;
   int unsigned cur_late_dly = 100;
   logic        pend = 1'b0;
   int unsigned cnt = 0;
   logic [7:0]  val = 8'd0;
   logic [31:0] kk;
   int unsigned dly;
   logic [7:0]  echo;

   assign kk   = sent_total - base;
   assign dly  = cur_late[kk[3:0]] ? cur_late_dly : cur_delay;
   assign echo = cur_bad[kk[3:0]] ? 8'h55 : tx_data + 8'd1;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      m_rx_valid <= 1'b0;
      if (pend) begin
         if (cnt == 0) begin
            m_rx_valid <= 1'b1;
            m_rx_data  <= val;
            pend       <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
      if (tx_valid) begin
         sent_total <= sent_total + 1;
         if (kk < NB) tx_cyc[kk[3:0]] <= cyc;
         if (tx_data != SEED + kk[7:0]) seq_err <= seq_err + 1;
         if (!cur_drop[kk[3:0]]) begin
            if (dly <= 1) begin
               m_rx_valid <= 1'b1;
               m_rx_data  <= echo;
               pend       <= 1'b0;
            end else begin
               pend <= 1'b1;
               cnt  <= dly - 2;
               val  <= echo;
            end
         end else begin
            pend <= 1'b0;
         end
      end
   end

   typedef struct {
      logic [15:0] bad;
      logic [15:0] drop;
      logic [15:0] late;
      int unsigned dly;
      int unsigned late_dly;
      int exp_pass;
      int exp_fail;
      int exp_to;
      int exp_lb;
      int exp_sent;
      int exp_gap;
   } vec_t;

   vec_t vecs [6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 40000) begin
         tick;
         n++;
      end
      chk(name, int'(done), 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tx_valid"}, int'(tx_valid), 0);
      chk({tag, "_tx_data"}, int'(tx_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass_count), 0);
      chk({tag, "_fail"}, int'(fail_count), 0);
      chk({tag, "_timeout"}, int'(timeout_count), 0);
      chk({tag, "_last_bad"}, int'(last_bad), 0);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   initial begin
      int n;
      int txs;
      rst_n     = 1'b0;
      start     = 1'b0;
      tx_ready  = 1'b1;
      inj_valid = 1'b0;
      inj_data  = 8'd0;

      vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 100, 100,
                  16, 0, 0, 8'h00, 16, 102};
`ifdef UART_CHK_ABORT_ON_FAIL_EN
      vecs[1] = '{16'h0004, 16'h0000, 16'h0000, 100, 100,
                  2, 1, 0, 8'h55, 3, 0};
      vecs[2] = '{16'h0000, 16'h0007, 16'h0000, 5, 5,
                  0, 1, 1, 8'h55, 1, 0};
`else
      vecs[1] = '{16'h0004, 16'h0000, 16'h0000, 100, 100,
                  15, 1, 0, 8'h55, 16, 0};
      vecs[2] = '{16'h0000, 16'h0007, 16'h0000, 5, 5,
                  13, 3, 3, 8'h55, 16, 1001};
`endif
      vecs[3] = '{16'h0000, 16'h0000, 16'h0001, 100, 999,
                  16, 0, 0, 8'h55, 16, 0};
      vecs[4] = '{16'h0000, 16'h0000, 16'h8000, 100, 1000,
                  15, 1, 1, 8'h55, 16, 0};
      vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 1, 1,
                  16, 0, 0, 8'h55, 16, 3};

      repeat (3) tick;
      check_reset("rst0");
      rst_n = 1'b1;
      tick;

      foreach (vecs[i]) begin
         cur_bad      = vecs[i].bad;
         cur_drop     = vecs[i].drop;
         cur_late     = vecs[i].late;
         cur_delay    = vecs[i].dly;
         cur_late_dly = vecs[i].late_dly;
         base         = sent_total;
         pulse_start;
         wait_done($sformatf("v%0d_done", i));
         repeat (5) tick;
         chk($sformatf("v%0d_pass", i), int'(pass_count), vecs[i].exp_pass);
         chk($sformatf("v%0d_fail", i), int'(fail_count), vecs[i].exp_fail);
         chk($sformatf("v%0d_timeout", i), int'(timeout_count), vecs[i].exp_to);
         chk($sformatf("v%0d_last_bad", i), int'(last_bad), vecs[i].exp_lb);
         chk($sformatf("v%0d_sent", i), int'(sent_total - base), vecs[i].exp_sent);
         chk($sformatf("v%0d_seq_err", i), int'(seq_err), 0);
         chk($sformatf("v%0d_busy", i), int'(busy), 0);
         if (vecs[i].exp_gap != 0)
            chk($sformatf("v%0d_gap", i), int'(tx_cyc[1] - tx_cyc[0]), vecs[i].exp_gap);
      end

      cur_bad   = '0;
      cur_drop  = '0;
      cur_late  = '0;
      cur_delay = 100;

      // latency after start, then a start pulse while busy
      base = sent_total;
      pulse_start;
      chk("lat_busy", int'(busy), 1);
      chk("lat_done", int'(done), 0);
      chk("lat_pass_clr", int'(pass_count), 0);
      chk("lat_tx_valid0", int'(tx_valid), 0);
      tick;
      chk("lat_tx_valid1", int'(tx_valid), 1);
      chk("lat_tx_data", int'(tx_data), 8'hF8);
      tick;
      chk("lat_tx_valid2", int'(tx_valid), 0);
      pulse_start;
      wait_done("busy_start_done");
      chk("busy_start_pass", int'(pass_count), 16);
      chk("busy_start_sent", int'(sent_total - base), 16);

      // tx_ready held low with an rx strobe during SEND
      tx_ready = 1'b0;
      base = sent_total;
      pulse_start;
      txs = 0;
      for (int i = 0; i < 500; i++) begin
         if (i == 100) begin
            inj_valid = 1'b1;
            inj_data  = 8'hF9;
         end
         tick;
         inj_valid = 1'b0;
         if (tx_valid) txs++;
      end
      chk("hold_tx_valid", txs, 0);
      chk("hold_pass", int'(pass_count), 0);
      chk("hold_fail", int'(fail_count), 0);
      tx_ready = 1'b1;
      txs = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (tx_valid) txs++;
      end
      chk("hold_pulse", txs, 1);
      wait_done("hold_done");
      chk("hold_pass_end", int'(pass_count), 16);

      // reset while waiting for the echo of byte 5
      base = sent_total;
      pulse_start;
      n = 0;
      while (kk < 5 && n < 5000) begin
         tick;
         n++;
      end
      chk("mid_reached", int'(kk), 5);
      repeat (10) tick;
      rst_n = 1'b0;
      tick;
      check_reset("mid_rst");
      rst_n = 1'b1;
      repeat (150) tick;
      chk("mid_idle_pass", int'(pass_count), 0);
      chk("mid_idle_busy", int'(busy), 0);
      base = sent_total;
      pulse_start;
      wait_done("clean_done");
      chk("clean_pass", int'(pass_count), 16);
      chk("clean_fail", int'(fail_count), 0);
      chk("clean_sent", int'(sent_total - base), 16);
      chk("clean_seq_err", int'(seq_err), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_echo_checker.md
UART_ECHO_CHECKER -- requirements
Module: uart_echo_checker

Interface
REQ-001 Parameter NUM_BYTES, default 16, number of bytes sent per test run (1..256).
REQ-002 Parameter SEED, default 8'h00, value of the first byte sent; byte k = SEED + k mod 256.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles to wait for each echo.
REQ-004 clk  input  1  single system clock (100 MHz); all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 tx_data  output  8  byte to the UART transmitter.
REQ-008 tx_valid  output  1  one-cycle request to the UART transmitter.
REQ-009 tx_ready  input  1  UART transmitter idle and able to accept a byte.
REQ-010 rx_data  input  8  byte from the UART receiver.
REQ-011 rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-012 busy  output  1  high in SEND or WAIT_RX.
REQ-013 done  output  1  high in DONE.
REQ-014 pass_count  output  8  echoes that matched the expected value.
REQ-015 fail_count  output  8  mismatches plus timeouts.
REQ-016 timeout_count  output  8  echoes that never arrived.
REQ-017 last_bad  output  8  rx_data of the most recent mismatch.

Function
REQ-018 FSM states: IDLE, SEND, WAIT_RX, DONE.
REQ-019 IDLE/DONE + start: clear pass/fail/timeout counters and byte index; go to SEND next cycle.
REQ-020 SEND: when tx_ready=1, drive tx_data=SEED+index and tx_valid=1 for exactly one cycle; latch the expected value (sent+1 mod 256); clear the timer; go to WAIT_RX. If tx_ready=0, wait in SEND with tx_valid=0.
REQ-021 WAIT_RX: the timer increments every cycle. On rx_valid, compare rx_data with the expected value. A match increments pass_count. A mismatch increments fail_count and loads last_bad.
REQ-022 WAIT_RX timeout: timer reaches TIMEOUT_CYCLES-1 with no rx_valid. Increment fail_count and timeout_count. last_bad is unchanged.
REQ-023 After a compare or timeout: if index = NUM_BYTES-1, go to DONE; otherwise increment index and return to SEND.
REQ-024 rx_valid and timeout in the same cycle: rx_valid wins; the result is a compare, not a timeout.
REQ-025 rx_valid in IDLE, SEND or DONE is ignored; no counter changes.
REQ-026 start while busy is ignored.
REQ-027 Expected-value arithmetic is 8-bit wrap: sent 8'hFF expects 8'h00.
REQ-028 Counters saturate at 8'hFF and do not wrap.
REQ-029 DONE holds all counters and done=1 until the next start.
REQ-030 Latency: tx_valid asserts one cycle after SEND is entered with tx_ready=1. The counter update is visible one cycle after the rx_valid cycle.

Reset
REQ-031 rst_n=0 at a clk edge: state=IDLE; tx_valid=0, tx_data=0, busy=0, done=0, all counters=0, last_bad=0, index=0, timer=0.
REQ-032 Reset mid-run aborts the run immediately with no partial result retained; start is required afterwards.

Configuration
REQ-033 Macro UART_CHK_ABORT_ON_FAIL_EN: when defined, the first mismatch or timeout goes directly to DONE after the counter update, and the remaining bytes are not sent. When undefined, all NUM_BYTES bytes are always sent.

Verification
REQ-034 Model that echoes byte+1 after 100 cycles, NUM_BYTES=16, SEED=0, start -> pass_count=16, fail_count=0, done=1.
REQ-035 SEED=8'hFE, NUM_BYTES=4, correct echo -> sent FE,FF,00,01; expected FF,00,01,02; pass_count=4.
REQ-036 Echo returns 8'h55 for the third byte -> fail_count=1, last_bad=8'h55, pass_count=15 (macro off); with UART_CHK_ABORT_ON_FAIL_EN, done after the third byte and pass_count=2.
REQ-037 No echo, TIMEOUT_CYCLES=1000, NUM_BYTES=3 -> timeout_count=3, fail_count=3; each byte sent 1000 cycles after the previous wait began (plus SEND cycles).
REQ-038 tx_ready held low 500 cycles -> tx_valid stays 0 until tx_ready=1, then a single-cycle pulse; rx_valid injected during SEND causes no counter change.
REQ-039 rst_n=0 during WAIT_RX of byte 5 -> next cycle all outputs at reset values; a new start runs a full clean pass.
